// File: rtl/grf_scoreboard.sv
// General register file with per-register pending-write counters (scoreboard).
// Optional macro GRF_BYPASS_EN forwards same-cycle write data to the read ports.
module grf_scoreboard #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] a1,
  input  logic [ADDR_W-1:0] a2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              hz1,
  output logic              hz2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic              pend_any
);

  localparam int NREG = 2**ADDR_W;
  localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0]  CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};

  logic [DATA_W-1:0] regs_r     [NREG];
  logic [CNT_W-1:0]  cnt_r      [NREG];
  logic [CNT_W-1:0]  cnt_next_s [NREG];
  logic              pend_next_s;
  logic              pend_any_r;
  logic              wr_live_s;
  logic              iss_live_s;
  logic              byp1_s;
  logic              byp2_s;

  assign wr_live_s  = we && (wa != ADDR_ZERO);
  assign iss_live_s = iss_valid && iss_ready && (iss_rd != ADDR_ZERO);
  assign pend_any   = pend_any_r;

`ifdef GRF_BYPASS_EN
  assign byp1_s = wr_live_s && (wa == a1);
  assign byp2_s = wr_live_s && (wa == a2);
`else
  assign byp1_s = 1'b0;
  assign byp2_s = 1'b0;
`endif

  // Issue acceptance: room in the counter, or a retiring write frees a slot this cycle
  always_comb begin
    iss_ready = 1'b0;
    if (iss_rd == ADDR_ZERO) begin
      iss_ready = 1'b1;
    end else if (cnt_r[iss_rd] != CNT_MAX) begin
      iss_ready = 1'b1;
    end else if (wr_live_s && (wa == iss_rd)) begin
      iss_ready = 1'b1;
    end else begin
      iss_ready = 1'b0;
    end
  end

  // Next counter values; an issue and a write to the same register cancel out
  always_comb begin
    pend_next_s = 1'b0;
    for (int i = 0; i < NREG; i++) begin
      cnt_next_s[i] = cnt_r[i];
      if (iss_live_s && (iss_rd == ADDR_W'(i))) begin
        if (wr_live_s && (wa == ADDR_W'(i))) begin
          cnt_next_s[i] = cnt_r[i];
        end else begin
          cnt_next_s[i] = cnt_r[i] + CNT_ONE;
        end
      end else if (wr_live_s && (wa == ADDR_W'(i)) && (cnt_r[i] != CNT_ZERO)) begin
        cnt_next_s[i] = cnt_r[i] - CNT_ONE;
      end else begin
        cnt_next_s[i] = cnt_r[i];
      end
      pend_next_s = pend_next_s | (cnt_next_s[i] != CNT_ZERO);
    end
  end

  // Register file, counters and the registered pending summary
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= DATA_ZERO;
        cnt_r[i]  <= CNT_ZERO;
      end
      pend_any_r <= 1'b0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        cnt_r[i] <= cnt_next_s[i];
      end
      if (wr_live_s) begin
        regs_r[wa] <= wd;
      end
      pend_any_r <= pend_next_s;
    end
  end

  // Read port 1: data and hazard (last reservation retired by a bypassed write clears it)
  always_comb begin
    rd1 = regs_r[a1];
    hz1 = 1'b0;
    if (byp1_s) begin
      rd1 = wd;
    end else begin
      rd1 = regs_r[a1];
    end
    if (a1 == ADDR_ZERO) begin
      hz1 = 1'b0;
    end else if (cnt_r[a1] == CNT_ZERO) begin
      hz1 = 1'b0;
    end else if (byp1_s && (cnt_r[a1] == CNT_ONE)) begin
      hz1 = 1'b0;
    end else begin
      hz1 = 1'b1;
    end
  end

  // Read port 2: same rules as port 1
  always_comb begin
    rd2 = regs_r[a2];
    hz2 = 1'b0;
    if (byp2_s) begin
      rd2 = wd;
    end else begin
      rd2 = regs_r[a2];
    end
    if (a2 == ADDR_ZERO) begin
      hz2 = 1'b0;
    end else if (cnt_r[a2] == CNT_ZERO) begin
      hz2 = 1'b0;
    end else if (byp2_s && (cnt_r[a2] == CNT_ONE)) begin
      hz2 = 1'b0;
    end else begin
      hz2 = 1'b1;
    end
  end

endmodule

// File: tb/tb_grf_scoreboard.sv
// Self-checking bench for grf_scoreboard: directed scenarios plus random traffic
// compared against a reference model of counters and register contents.
module tb_grf_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  a1, a2, iss_rd, wa;
  logic [31:0] rd1, rd2, wd;
  logic        hz1, hz2, iss_valid, iss_ready, we, pend_any;

  int          total = 0;
  int          bad = 0;
  int          m_cnt [32];
  logic [31:0] m_reg [32];

  grf_scoreboard dut (
    .clk(clk), .reset(reset), .a1(a1), .a2(a2), .rd1(rd1), .rd2(rd2),
    .hz1(hz1), .hz2(hz2), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .iss_ready(iss_ready), .we(we), .wa(wa), .wd(wd), .pend_any(pend_any)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

`ifdef GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  function automatic bit wr_hits(input logic [4:0] a);
    return we && (wa != 5'd0) && (wa == a);
  endfunction

  function automatic logic [31:0] m_rd(input logic [4:0] a);
    if (BYP && wr_hits(a)) return wd;
    return m_reg[a];
  endfunction

  function automatic bit m_hz(input logic [4:0] a);
    if (a == 5'd0 || m_cnt[a] == 0) return 1'b0;
    if (BYP && wr_hits(a) && m_cnt[a] == 1) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    return (iss_rd == 5'd0) || (m_cnt[iss_rd] < 3) || wr_hits(iss_rd);
  endfunction

  function automatic bit m_pend();
    for (int i = 0; i < 32; i++) if (m_cnt[i] != 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic set_in(input bit r, input bit iv, input logic [4:0] ird, input bit w,
                        input logic [4:0] wav, input logic [31:0] wdv,
                        input logic [4:0] a1v, input logic [4:0] a2v);
    reset = r; iss_valid = iv; iss_rd = ird; we = w; wa = wav; wd = wdv; a1 = a1v; a2 = a2v;
    #1;
  endtask

  // Compare all outputs to the model, then clock and apply the model's update rules.
  task automatic tick();
    bit acc;
    check("rd1", rd1, m_rd(a1));
    check("rd2", rd2, m_rd(a2));
    check("hz1", {31'd0, hz1}, {31'd0, m_hz(a1)});
    check("hz2", {31'd0, hz2}, {31'd0, m_hz(a2)});
    check("iss_ready", {31'd0, iss_ready}, {31'd0, m_ready()});
    check("pend_any", {31'd0, pend_any}, {31'd0, m_pend()});
    acc = iss_valid && m_ready();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin m_cnt[i] = 0; m_reg[i] = 32'd0; end
    end else begin
      if (acc && iss_rd != 5'd0 && wr_hits(iss_rd)) begin
        m_reg[wa] = wd;
      end else begin
        if (acc && iss_rd != 5'd0) m_cnt[iss_rd] = m_cnt[iss_rd] + 1;
        if (we && wa != 5'd0) begin
          if (m_cnt[wa] > 0) m_cnt[wa] = m_cnt[wa] - 1;
          m_reg[wa] = wd;
        end
      end
    end
    #1;
  endtask

  task automatic step(input bit r, input bit iv, input logic [4:0] ird, input bit w,
                      input logic [4:0] wav, input logic [31:0] wdv,
                      input logic [4:0] a1v, input logic [4:0] a2v);
    set_in(r, iv, ird, w, wav, wdv, a1v, a2v);
    tick();
  endtask

  initial begin
    for (int i = 0; i < 32; i++) begin m_cnt[i] = 0; m_reg[i] = 32'd0; end
    set_in(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    @(posedge clk); #1;
    @(posedge clk); #1;

    // post-reset state
    set_in(1'b0, 1'b0, 5'd3, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
    check("rst_rd1", rd1, 32'd0);
    check("rst_hz1", {31'd0, hz1}, 32'd0);
    check("rst_pend", {31'd0, pend_any}, 32'd0);
    check("rst_ready", {31'd0, iss_ready}, 32'd1);
    tick();

    // write and read back, register 0 stays zero
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    check("wr5_rd1", rd1, 32'hDEADBEEF);
    check("wr5_hz1", {31'd0, hz1}, 32'd0);
    tick();
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 32'h1234, 5'd0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("r0_rd2", rd2, 32'd0);
    tick();

    // counter saturation on register 7
    repeat (3) step(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    set_in(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    check("full_ready", {31'd0, iss_ready}, 32'd0);
    tick();
    set_in(1'b0, 1'b1, 5'd7, 1'b1, 5'd7, 32'h77, 5'd7, 5'd0);
    check("full_wr_ready", {31'd0, iss_ready}, 32'd1);
    tick();
    set_in(1'b0, 1'b1, 5'd7, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    check("still_full", {31'd0, iss_ready}, 32'd0);
    check("full_pend", {31'd0, pend_any}, 32'd1);
    tick();
    repeat (3) step(1'b0, 1'b0, 5'd0, 1'b1, 5'd7, 32'h70, 5'd7, 5'd0);

    // hazard on register 3 and its release
    step(1'b0, 1'b1, 5'd3, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    check("hz3_set", {31'd0, hz1}, 32'd1);
    tick();
    set_in(1'b0, 1'b0, 5'd0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd0);
    if (BYP) begin
      check("byp_rd1", rd1, 32'hA5A5A5A5);
      check("byp_hz1", {31'd0, hz1}, 32'd0);
    end else begin
      check("nobyp_hz1", {31'd0, hz1}, 32'd1);
    end
    tick();
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd3, 5'd0);
    check("hz3_clr", {31'd0, hz1}, 32'd0);
    check("rd3_after", rd1, 32'hA5A5A5A5);
    tick();

    // simultaneous issue and write on register 9 with one pending
    step(1'b0, 1'b1, 5'd9, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd9, 1'b1, 5'd9, 32'h99, 5'd9, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    check("r9_hz1", {31'd0, hz1}, 32'd1);
    check("r9_rd1", rd1, 32'h99);
    tick();
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd9, 32'h9A, 5'd0, 5'd0);

    // reset discards reservations
    step(1'b0, 1'b1, 5'd4, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b0, 1'b1, 5'd6, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    step(1'b1, 1'b1, 5'd4, 1'b1, 5'd6, 32'h66, 5'd0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd3);
    check("mrst_pend", {31'd0, pend_any}, 32'd0);
    check("mrst_rd1", rd1, 32'd0);
    check("mrst_rd2", rd2, 32'd0);
    tick();
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd4, 32'h44, 5'd0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd0);
    check("w4_pend", {31'd0, pend_any}, 32'd0);
    tick();

    // write with no reservation does not underflow
    step(1'b0, 1'b0, 5'd0, 1'b1, 5'd10, 32'h1010, 5'd0, 5'd0);
    set_in(1'b0, 1'b0, 5'd0, 1'b0, 5'd0, 32'd0, 5'd10, 5'd0);
    check("w10_rd1", rd1, 32'h1010);
    check("w10_pend", {31'd0, pend_any}, 32'd0);
    tick();

    // random traffic concentrated on a few registers to provoke collisions
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 199) == 0),
           $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
           $urandom_range(0, 9) < 4, 5'($urandom_range(0, 7)), $urandom(),
           ($urandom_range(0, 3) == 0) ? 5'($urandom()) : 5'($urandom_range(0, 7)),
           5'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
